// File: rtl/freq_meter_pkg.sv
// Shared types and gate-length helpers for the frequency meter.
package freq_meter_pkg;

    localparam int unsigned GATE_SEL_W = 2;
    localparam int unsigned LEN_W      = 32;
    localparam int unsigned PER_W      = 32;

    typedef enum logic {
        ST_ARM  = 1'b0,
        ST_GATE = 1'b1
    } state_t;

    // Decade multiplier applied to the base gate length.
    function automatic logic [LEN_W-1:0] pow10(input logic [GATE_SEL_W-1:0] sel);
        logic [LEN_W-1:0] p;
        case (sel)
            2'd0:    p = LEN_W'(1);
            2'd1:    p = LEN_W'(10);
            2'd2:    p = LEN_W'(100);
            default: p = LEN_W'(1000);
        endcase
        return p;
    endfunction

    // Terminal gate_cnt value for a window of base*10^sel cycles.
    function automatic logic [LEN_W-1:0] gate_last(input int unsigned base,
                                                   input logic [GATE_SEL_W-1:0] sel);
        return (LEN_W'(base) * pow10(sel)) - LEN_W'(1);
    endfunction

endpackage

// File: rtl/sig_edge_sync.sv
// Two-flop synchronizer plus delay flop producing a one-cycle rising-edge pulse.
module sig_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise_c
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise_c = s2 & ~s3;

endmodule

// File: rtl/freq_meter.sv
// Gated rising-edge frequency meter; FREQ_METER_PERIOD_EN adds a period counter.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned GATE_BASE = CLK_HZ / 100,
    parameter int unsigned EDGE_W    = 32
) (
    input  logic                  clk_100M,
    input  logic                  rst_n,
    input  logic                  sig_i,
    input  logic [GATE_SEL_W-1:0] gate_sel_i,
    output logic [EDGE_W-1:0]     freq_o,
    output logic [GATE_SEL_W-1:0] gate_o,
    output logic                  valid_o,
    output logic                  ovf_o
`ifdef FREQ_METER_PERIOD_EN
    ,
    output logic [PER_W-1:0]      period_o,
    output logic                  period_valid_o
`endif
);

    logic                  rise_c;
    state_t                state;
    state_t                state_d;
    logic [GATE_SEL_W-1:0] sel_q;
    logic [LEN_W-1:0]      last_q;
    logic [LEN_W-1:0]      gate_cnt;
    logic [LEN_W-1:0]      gate_cnt_d;
    logic [EDGE_W-1:0]     edge_cnt;
    logic [EDGE_W-1:0]     edge_cnt_d;
    logic                  sat;
    logic                  sat_d;
    logic [EDGE_W-1:0]     freq_d;
    logic [GATE_SEL_W-1:0] gate_d;
    logic                  valid_d;
    logic                  ovf_d;

    logic                  sel_chg_c;
    logic                  gate_end_c;
    logic                  edge_full_c;
    logic [EDGE_W-1:0]     edge_sum_c;
    logic                  sat_now_c;

    sig_edge_sync u_sync (
        .clk    (clk_100M),
        .rst_n  (rst_n),
        .sig    (sig_i),
        .rise_c (rise_c)
    );

    assign sel_chg_c   = (gate_sel_i != sel_q);
    assign gate_end_c  = (gate_cnt == last_q);
    assign edge_full_c = &edge_cnt;
    assign edge_sum_c  = (rise_c && !edge_full_c) ? edge_cnt + EDGE_W'(1) : edge_cnt;
    assign sat_now_c   = sat | (rise_c & edge_full_c);

    // Selector copy and its gate length move together, so last_q always matches sel_q.
    always_ff @(posedge clk_100M) begin
        if (!rst_n) begin
            state    <= ST_ARM;
            sel_q    <= '0;
            last_q   <= gate_last(GATE_BASE, '0);
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            freq_o   <= '0;
            gate_o   <= '0;
            valid_o  <= 1'b0;
            ovf_o    <= 1'b0;
        end else begin
            state    <= state_d;
            sel_q    <= gate_sel_i;
            last_q   <= gate_last(GATE_BASE, gate_sel_i);
            gate_cnt <= gate_cnt_d;
            edge_cnt <= edge_cnt_d;
            sat      <= sat_d;
            freq_o   <= freq_d;
            gate_o   <= gate_d;
            valid_o  <= valid_d;
            ovf_o    <= ovf_d;
        end
    end

    // Next-state and result logic; a selector change overrides any gate end.
    always_comb begin
        state_d    = state;
        gate_cnt_d = gate_cnt + LEN_W'(1);
        edge_cnt_d = edge_cnt;
        sat_d      = sat;
        freq_d     = freq_o;
        gate_d     = gate_o;
        valid_d    = 1'b0;
        ovf_d      = ovf_o;

        if (sel_chg_c) begin
            state_d    = ST_ARM;
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            sat_d      = 1'b0;
        end else begin
            case (state)
                ST_ARM: begin
                    if (rise_c) begin
                        // Aligning edge opens the window and is not counted.
                        state_d    = ST_GATE;
                        gate_cnt_d = LEN_W'(1);
                        edge_cnt_d = '0;
                        sat_d      = 1'b0;
                    end else if (gate_end_c) begin
                        gate_cnt_d = '0;
                        freq_d     = '0;
                        ovf_d      = 1'b0;
                        gate_d     = sel_q;
                        valid_d    = 1'b1;
                    end
                end
                ST_GATE: begin
                    edge_cnt_d = edge_sum_c;
                    sat_d      = sat_now_c;
                    if (gate_end_c) begin
                        freq_d     = edge_sum_c;
                        ovf_d      = sat_now_c;
                        gate_d     = sel_q;
                        valid_d    = 1'b1;
                        gate_cnt_d = '0;
                        edge_cnt_d = '0;
                        sat_d      = 1'b0;
                    end
                end
                default: begin
                    state_d    = ST_ARM;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                end
            endcase
        end
    end

`ifdef FREQ_METER_PERIOD_EN
    logic [PER_W-1:0] per_cnt;
    logic             per_seen;
    logic             per_full_c;

    assign per_full_c = &per_cnt;

    // Edge-to-edge cycle count; the first edge after arming only starts the count.
    always_ff @(posedge clk_100M) begin
        if (!rst_n) begin
            per_cnt        <= '0;
            per_seen       <= 1'b0;
            period_o       <= '0;
            period_valid_o <= 1'b0;
        end else begin
            period_valid_o <= 1'b0;
            if (sel_chg_c) begin
                per_cnt  <= '0;
                per_seen <= 1'b0;
            end else if (rise_c) begin
                per_cnt  <= '0;
                per_seen <= 1'b1;
                if (per_seen) begin
                    period_o       <= per_full_c ? per_cnt : per_cnt + PER_W'(1);
                    period_valid_o <= 1'b1;
                end
            end else if (!per_full_c) begin
                per_cnt <= per_cnt + PER_W'(1);
            end
        end
    end
`else
    // Period measurement not built; frequency path is unaffected.
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: full-width and 4-bit instances share all stimulus.
module tb_freq_meter;

    logic        clk_100M;
    logic        rst_n;
    logic        sig_i;
    logic [1:0]  gate_sel_i;
    logic [31:0] freq_o;
    logic [1:0]  gate_o;
    logic        valid_o;
    logic        ovf_o;
    logic [3:0]  s_freq;
    logic [1:0]  s_gate;
    logic        s_valid;
    logic        s_ovf;
`ifdef FREQ_METER_PERIOD_EN
    logic [31:0] period_o;
    logic        period_valid_o;
    logic [31:0] s_period;
    logic        s_period_valid;
`endif

    int unsigned sig_per;
    int unsigned ph;
    int unsigned n_run;
    int unsigned n_fail;
    int unsigned w;

    freq_meter #(.GATE_BASE(100), .EDGE_W(32)) u_dut (
        .clk_100M       (clk_100M),
        .rst_n          (rst_n),
        .sig_i          (sig_i),
        .gate_sel_i     (gate_sel_i),
        .freq_o         (freq_o),
        .gate_o         (gate_o),
        .valid_o        (valid_o),
        .ovf_o          (ovf_o)
`ifdef FREQ_METER_PERIOD_EN
        ,
        .period_o       (period_o),
        .period_valid_o (period_valid_o)
`endif
    );

    freq_meter #(.GATE_BASE(100), .EDGE_W(4)) u_small (
        .clk_100M       (clk_100M),
        .rst_n          (rst_n),
        .sig_i          (sig_i),
        .gate_sel_i     (gate_sel_i),
        .freq_o         (s_freq),
        .gate_o         (s_gate),
        .valid_o        (s_valid),
        .ovf_o          (s_ovf)
`ifdef FREQ_METER_PERIOD_EN
        ,
        .period_o       (s_period),
        .period_valid_o (s_period_valid)
`endif
    );

    initial begin
        clk_100M = 1'b0;
        forever #5 clk_100M = ~clk_100M;
    end

    // Square wave: high for the first half of each sig_per-cycle period, 0 = held low.
    initial begin
        sig_i = 1'b0;
        ph    = 0;
        forever begin
            @(negedge clk_100M);
            if (sig_per == 0) begin
                ph    = 0;
                sig_i = 1'b0;
            end else begin
                ph    = (ph + 1 >= sig_per) ? 0 : ph + 1;
                sig_i = (ph < sig_per / 2);
            end
        end
    end

    task automatic tick();
        @(posedge clk_100M);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int unsigned budget,
                              output int unsigned waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!valid_o && waited < budget);
        check({tag, "_seen"}, 64'(valid_o), 64'd1);
    endtask

`ifdef FREQ_METER_PERIOD_EN
    task automatic wait_pvalid(input string tag, input int unsigned budget);
        int unsigned n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!period_valid_o && n < budget);
        check({tag, "_seen"}, 64'(period_valid_o), 64'd1);
    endtask
`endif

    initial begin
        n_run      = 0;
        n_fail     = 0;
        sig_per    = 0;
        rst_n      = 1'b0;
        gate_sel_i = 2'd0;
        repeat (3) tick();

        check("rst_freq",  64'(freq_o),  64'd0);
        check("rst_gate",  64'(gate_o),  64'd0);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_ovf",   64'(ovf_o),   64'd0);
        rst_n = 1'b1;

        // DC input reports zero every 100 cycles.
        wait_valid("dc1", 150, w);
        check("dc1_lat",  64'(w),      64'd100);
        check("dc1_freq", 64'(freq_o), 64'd0);
        check("dc1_gate", 64'(gate_o), 64'd0);
        check("dc1_ovf",  64'(ovf_o),  64'd0);
        wait_valid("dc2", 150, w);
        check("dc2_lat",  64'(w),      64'd100);
        check("dc2_freq", 64'(freq_o), 64'd0);

        // Period 10 with 100-cycle gate; first window excludes the aligning edge.
        sig_per = 10;
        wait_valid("p10_first", 300, w);
        check("p10_first_freq", 64'(freq_o >= 9 && freq_o <= 10), 64'd1);
        wait_valid("p10_a", 150, w);
        check("p10_a_lat",   64'(w),      64'd100);
        check("p10_a_freq",  64'(freq_o), 64'd10);
        check("p10_a_ovf",   64'(ovf_o),  64'd0);
        check("p10_a_gate",  64'(gate_o), 64'd0);
        check("p10_a_sfreq", 64'(s_freq), 64'd10);
        check("p10_a_sovf",  64'(s_ovf),  64'd0);
        tick();
        check("p10_no_dbl",  64'(valid_o), 64'd0);
        wait_valid("p10_b", 150, w);
        check("p10_b_lat",   64'(w),      64'd99);
        check("p10_b_freq",  64'(freq_o), 64'd10);

        // Selector change mid-window aborts it; results hold until next gate.
        repeat (49) tick();
        gate_sel_i = 2'd1;
        tick();
        check("chg_valid", 64'(valid_o), 64'd0);
        check("chg_freq",  64'(freq_o),  64'd10);
        check("chg_gate",  64'(gate_o),  64'd0);
        wait_valid("sel1_first", 1100, w);
        check("sel1_no_early", 64'(w >= 1000), 64'd1);
        check("sel1_first_freq", 64'(freq_o >= 99 && freq_o <= 100), 64'd1);
        check("sel1_first_gate", 64'(gate_o), 64'd1);
        wait_valid("sel1_b", 1100, w);
        check("sel1_b_lat",  64'(w),      64'd1000);
        check("sel1_b_freq", 64'(freq_o), 64'd100);
        check("sel1_b_gate", 64'(gate_o), 64'd1);

        // Saturation on the 4-bit instance: 25 edges clamp to 15.
        gate_sel_i = 2'd0;
        wait_valid("sel0_re", 200, w);
        sig_per = 4;
        wait_valid("p4_mix", 200, w);
        wait_valid("p4", 200, w);
        check("p4_sfreq", 64'(s_freq), 64'd15);
        check("p4_sovf",  64'(s_ovf),  64'd1);
        check("p4_freq",  64'(freq_o), 64'd25);
        check("p4_ovf",   64'(ovf_o),  64'd0);
        sig_per = 20;
        wait_valid("p20_mix", 200, w);
        wait_valid("p20", 200, w);
        check("p20_sfreq", 64'(s_freq), 64'd5);
        check("p20_sovf",  64'(s_ovf),  64'd0);
        check("p20_freq",  64'(freq_o), 64'd5);

        // One-cycle reset mid-gate clears results, then the meter re-arms.
        repeat (30) tick();
        sig_per = 10;
        rst_n = 1'b0;
        tick();
        check("mrst_freq",  64'(freq_o),  64'd0);
        check("mrst_sfreq", 64'(s_freq),  64'd0);
        check("mrst_gate",  64'(gate_o),  64'd0);
        check("mrst_valid", 64'(valid_o), 64'd0);
        check("mrst_ovf",   64'(ovf_o),   64'd0);
        rst_n = 1'b1;
        wait_valid("mrst_first", 200, w);
        check("mrst_first_lat",  64'(w >= 100 && w <= 115), 64'd1);
        check("mrst_first_freq", 64'(freq_o >= 9 && freq_o <= 10), 64'd1);

`ifdef FREQ_METER_PERIOD_EN
        // Edge-to-edge period, before and after a rate change.
        wait_pvalid("per10_a", 40);
        check("per10_a", 64'(period_o), 64'd10);
        wait_pvalid("per10_b", 40);
        check("per10_b", 64'(period_o), 64'd10);
        sig_per = 37;
        repeat (3) wait_pvalid("per37_skip", 80);
        wait_pvalid("per37_a", 80);
        check("per37_a", 64'(period_o), 64'd37);
        wait_pvalid("per37_b", 80);
        check("per37_b", 64'(period_o), 64'd37);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
